// File: rtl/win_unchange_checker.sv
// Window-unchange assertion checker: a start event captures test_expr, and any change
// seen before the end event closes the window produces a one-cycle fire pulse.
module win_unchange_checker #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     test_expr,
    input  logic                 start_event,
    input  logic                 end_event,
    output logic                 fire,
    output logic                 window_open,
    output logic [CNT_WIDTH-1:0] violation_count,
    output logic [CNT_WIDTH-1:0] window_count
);

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     ref_q, ref_d;
    logic                 fire_q, fire_d;
    logic [CNT_WIDTH-1:0] vcnt_q, vcnt_d;
    logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        fire_d  = 1'b0;
        vcnt_d  = vcnt_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                // end_event is meaningless here, even when it coincides with start
                if (start_event) begin
                    state_d = OPEN;
                    ref_d   = test_expr;
                    if (enable && wcnt_q != CNT_MAX) begin
                        wcnt_d = wcnt_q + CNT_ONE;
                    end
                end
            end
            OPEN: begin
                // The reference is never refreshed, so repeated changes fire repeatedly
                if (enable && test_expr != ref_q) begin
                    fire_d = 1'b1;
                    if (vcnt_q != CNT_MAX) begin
                        vcnt_d = vcnt_q + CNT_ONE;
                    end
                end
                if (end_event) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ref_q   <= '0;
            fire_q  <= 1'b0;
            vcnt_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            fire_q  <= fire_d;
            vcnt_q  <= vcnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign fire            = fire_q;
    assign window_open     = (state_q == OPEN);
    assign violation_count = vcnt_q;
    assign window_count    = wcnt_q;

endmodule

// File: tb/tb_win_unchange_checker.sv
// Scoreboard bench for win_unchange_checker: a window-level reference model queues the
// expected outputs per edge, and a monitor compares two instances (wide and narrow counters).
module tb_win_unchange_checker;

    localparam int WIDTH  = 4;
    localparam int CW_BIG = 16;
    localparam int CW_SML = 3;

    typedef struct {
        logic fire;
        logic wopen;
        int   vcnt;
        int   wcnt;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic [WIDTH-1:0]  test_expr = '0;
    logic              start_event = 1'b0;
    logic              end_event = 1'b0;

    logic              fire_a, wopen_a, fire_b, wopen_b;
    logic [CW_BIG-1:0] vcnt_a, wcnt_a;
    logic [CW_SML-1:0] vcnt_b, wcnt_b;

    int pass_cnt  = 0;
    int total_cnt = 0;
    exp_t exp_q[$];

    // Reference model: is a window open, what was captured, how many events so far
    bit              m_open;
    bit [WIDTH-1:0]  m_ref;
    int              m_viol;
    int              m_win;

    always #5 clock = ~clock;

    win_unchange_checker #(.WIDTH(WIDTH), .CNT_WIDTH(CW_BIG)) dut (
        .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr),
        .start_event(start_event), .end_event(end_event), .fire(fire_a),
        .window_open(wopen_a), .violation_count(vcnt_a), .window_count(wcnt_a)
    );

    win_unchange_checker #(.WIDTH(WIDTH), .CNT_WIDTH(CW_SML)) dut_sat (
        .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr),
        .start_event(start_event), .end_event(end_event), .fire(fire_b),
        .window_open(wopen_b), .violation_count(vcnt_b), .window_count(wcnt_b)
    );

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drives one edge's inputs and queues what the outputs must look like after it
    task automatic applyStimulus(input bit rst, input bit en, input bit [WIDTH-1:0] te,
                                 input bit st, input bit ev);
        exp_t e;
        @(negedge clock);
        reset = rst; enable = en; test_expr = te; start_event = st; end_event = ev;
        e.fire = 1'b0;
        if (rst) begin
            m_open = 0; m_ref = '0; m_viol = 0; m_win = 0;
        end else if (!m_open) begin
            if (st) begin
                m_open = 1; m_ref = te;
                if (en) m_win++;
            end
        end else begin
            if (en && te != m_ref) begin
                e.fire = 1'b1;
                m_viol++;
            end
            if (ev) m_open = 0;
        end
        e.wopen = m_open;
        e.vcnt  = m_viol;
        e.wcnt  = m_win;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("fire",            {31'b0, fire_a},  {31'b0, e.fire});
        cmp("window_open",     {31'b0, wopen_a}, {31'b0, e.wopen});
        cmp("violation_count", 32'(vcnt_a),      32'(sat(e.vcnt, CW_BIG)));
        cmp("window_count",    32'(wcnt_a),      32'(sat(e.wcnt, CW_BIG)));
        cmp("sat_fire",        {31'b0, fire_b},  {31'b0, e.fire});
        cmp("sat_window_open", {31'b0, wopen_b}, {31'b0, e.wopen});
        cmp("sat_violation",   32'(vcnt_b),      32'(sat(e.vcnt, CW_SML)));
        cmp("sat_window",      32'(wcnt_b),      32'(sat(e.wcnt, CW_SML)));
    endtask

    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        bit [WIDTH-1:0] te;
        int drain;
        // Reset dominates every event
        applyStimulus(1, 1, 4'd1, 1, 0);
        applyStimulus(1, 1, 4'd1, 1, 0);
        applyStimulus(1, 1, 4'd8, 0, 0);
        applyStimulus(1, 1, 4'd8, 0, 1);
        // Clean window with start held two cycles
        applyStimulus(0, 1, 4'd5, 1, 0);
        applyStimulus(0, 1, 4'd5, 1, 0);
        repeat (5) applyStimulus(0, 1, 4'd5, 0, 0);
        applyStimulus(0, 1, 4'd5, 0, 1);
        // Value changes only after the window closed
        applyStimulus(0, 1, 4'd3, 1, 0);
        repeat (3) applyStimulus(0, 1, 4'd3, 0, 0);
        applyStimulus(0, 1, 4'd3, 0, 1);
        applyStimulus(0, 1, 4'd0, 0, 0);
        // Mid-window change, then change back (fires twice)
        applyStimulus(0, 1, 4'd3, 1, 0);
        applyStimulus(0, 1, 4'd7, 0, 0);
        applyStimulus(0, 1, 4'd7, 0, 0);
        applyStimulus(0, 1, 4'd3, 0, 0);
        applyStimulus(0, 1, 4'd3, 0, 1);
        // Change coincident with end, single-bit change
        applyStimulus(0, 1, 4'd2, 1, 0);
        applyStimulus(0, 1, 4'd3, 0, 1);
        // start and end together in IDLE opens the window
        applyStimulus(0, 1, 4'd6, 1, 1);
        applyStimulus(0, 1, 4'd6, 0, 0);
        applyStimulus(0, 1, 4'd6, 0, 1);
        // Immediate reopen after close captures new value
        applyStimulus(0, 1, 4'd9, 1, 0);
        applyStimulus(0, 1, 4'd9, 0, 0);
        // enable low suppresses fire and freezes counters
        applyStimulus(0, 0, 4'd4, 0, 0);
        applyStimulus(0, 0, 4'd4, 0, 1);
        applyStimulus(0, 0, 4'd1, 1, 0);
        applyStimulus(0, 0, 4'd2, 0, 1);
        // Reset mid-window abandons it
        applyStimulus(0, 1, 4'd5, 1, 0);
        applyStimulus(0, 1, 4'd6, 0, 0);
        applyStimulus(1, 1, 4'd6, 0, 0);
        applyStimulus(0, 1, 4'd6, 0, 0);
        applyStimulus(0, 1, 4'd6, 1, 0);
        applyStimulus(0, 1, 4'd6, 0, 1);

        // Randomised traffic; long enough to saturate the narrow counters
        te = 4'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 25) te = 4'($urandom);
            applyStimulus(($urandom_range(199) == 0), ($urandom_range(9) != 0), te,
                          ($urandom_range(3) == 0), ($urandom_range(4) == 0));
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clock);
            drain++;
        end
        #2;
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
